// File: rtl/vga_frame_monitor.sv
// VGA receive-side frame monitor: geometry check, checksum, probe pixel, Avalon-MM regs.
// Optional VGA_MON_CHECKSUM_EN adds the per-frame pixel checksum accumulator.
module vga_frame_monitor #(
  parameter int EXP_W      = 640,
  parameter int EXP_H      = 480,
  parameter int EXP_VTOTAL = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        VGA_CLK,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_n,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    ERR     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        vclk_q, vclk_d, hs_q, hs_d, vs_q, vs_d;
  logic        err_q, err_d, fd_q, fd_d, wbad_q, wbad_d;
  logic        irq_en_q, irq_en_d, irq_q, irq_d;
  logic [9:0]  x_q, x_d, y_q, y_d, px_q, px_d, py_q, py_d;
  logic [15:0] lpx_q, lpx_d, acth_q, acth_d, lt_q, lt_d;
  logic [15:0] maxw_q, maxw_d;
  logic [15:0] rw_q, rw_d, rh_q, rh_d, rlt_q, rlt_d;
  logic [15:0] fc_q, fc_d, pp_q, pp_d, rd_q, rd_d;
`ifdef VGA_MON_CHECKSUM_EN
  logic [15:0] cks_q, cks_d, rcks_q, rcks_d;
`endif

  logic pix_stb, hs_fall, vs_fall, match, clr;
  logic unused_bits;
  assign unused_bits = ^{writedata[15:10], VGA_R[2:0],
                         VGA_G[1:0], VGA_B[2:0]};

  assign pix_stb = VGA_CLK & ~vclk_q;
  assign hs_fall = hs_q & ~VGA_HS;
  assign vs_fall = vs_q & ~VGA_VS;
  assign clr     = chipselect & write &
                   (address == 3'd7) & writedata[0];

  always_comb begin
    vclk_d   = VGA_CLK;
    hs_d     = VGA_HS;
    vs_d     = VGA_VS;
    state_d  = state_q;
    err_d    = err_q;
    fd_d     = fd_q;
    wbad_d   = wbad_q;
    irq_en_d = irq_en_q;
    x_d      = x_q;
    y_d      = y_q;
    px_d     = px_q;
    py_d     = py_q;
    lpx_d    = lpx_q;
    acth_d   = acth_q;
    lt_d     = lt_q;
    maxw_d   = maxw_q;
    rw_d     = rw_q;
    rh_d     = rh_q;
    rlt_d    = rlt_q;
    fc_d     = fc_q;
    pp_d     = pp_q;
    rd_d     = rd_q;
    irq_d    = irq_en_q & fd_q;
`ifdef VGA_MON_CHECKSUM_EN
    cks_d    = cks_q;
    rcks_d   = rcks_q;
`endif

    if (pix_stb && VGA_BLANK_n) begin
      if (x_q == px_q && y_q == py_q)
        pp_d = {VGA_R[7:3], VGA_G[7:2], VGA_B[7:3]};
      x_d   = (x_q == 10'h3ff) ? x_q : x_q + 10'd1;
      lpx_d = lpx_q + 16'd1;
`ifdef VGA_MON_CHECKSUM_EN
      cks_d = cks_q + 16'(VGA_R) + 16'(VGA_G) + 16'(VGA_B);
`endif
    end

    // Line closes before any frame latch in the same cycle
    if (hs_fall) begin
      lt_d = lt_q + 16'd1;
      if (lpx_d != 16'd0) begin
        y_d    = (y_q == 10'h3ff) ? y_q : y_q + 10'd1;
        acth_d = acth_q + 16'd1;
        if (lpx_d != 16'(EXP_W)) wbad_d = 1'b1;
        if (lpx_d > maxw_q) maxw_d = lpx_d;
      end
      x_d   = '0;
      lpx_d = '0;
    end

    match = !wbad_d && acth_d == 16'(EXP_H) &&
            lt_d == 16'(EXP_VTOTAL);

    if (vs_fall) begin
      if (state_q != HUNT) begin
        rw_d  = maxw_d;
        rh_d  = acth_d;
        rlt_d = lt_d;
        fc_d  = fc_q + 16'd1;
        fd_d  = 1'b1;
`ifdef VGA_MON_CHECKSUM_EN
        rcks_d = cks_d;
`endif
      end
      unique case (state_q)
        HUNT:    state_d = MEASURE;
        MEASURE: begin
          state_d = match ? LOCKED : ERR;
          if (!match) err_d = 1'b1;
        end
        LOCKED: if (!match) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
        ERR:     state_d = ERR;
      endcase
      x_d    = '0;
      y_d    = '0;
      acth_d = '0;
      lt_d   = '0;
      maxw_d = '0;
      wbad_d = 1'b0;
`ifdef VGA_MON_CHECKSUM_EN
      cks_d  = '0;
`endif
    end

    if (chipselect && write) begin
      case (address)
        3'd5: px_d = writedata[9:0];
        3'd6: py_d = writedata[9:0];
        3'd7: irq_en_d = writedata[1];
        default: ;
      endcase
    end

    // Clear overrides the frame-end state and flag updates
    if (clr) begin
      err_d   = 1'b0;
      fd_d    = 1'b0;
      state_d = HUNT;
      x_d     = '0;
      y_d     = '0;
      lpx_d   = '0;
      acth_d  = '0;
      lt_d    = '0;
      maxw_d  = '0;
      wbad_d  = 1'b0;
`ifdef VGA_MON_CHECKSUM_EN
      cks_d   = '0;
`endif
    end

    if (chipselect && read) begin
      case (address)
        3'd0: rd_d = {12'b0, err_q, fd_q, state_q};
        3'd1: rd_d = rw_q;
        3'd2: rd_d = rh_q;
        3'd3: rd_d = rlt_q;
        3'd4: rd_d = fc_q;
`ifdef VGA_MON_CHECKSUM_EN
        3'd5: rd_d = rcks_q;
`else
        3'd5: rd_d = 16'h0000;
`endif
        3'd6: rd_d = pp_q;
        default: rd_d = {14'b0, irq_en_q, 1'b0};
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= HUNT;
      vclk_q   <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      err_q    <= 1'b0;
      fd_q     <= 1'b0;
      wbad_q   <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      px_q     <= '0;
      py_q     <= '0;
      lpx_q    <= '0;
      acth_q   <= '0;
      lt_q     <= '0;
      maxw_q   <= '0;
      rw_q     <= '0;
      rh_q     <= '0;
      rlt_q    <= '0;
      fc_q     <= '0;
      pp_q     <= '0;
      rd_q     <= '0;
`ifdef VGA_MON_CHECKSUM_EN
      cks_q    <= '0;
      rcks_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      vclk_q   <= vclk_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      err_q    <= err_d;
      fd_q     <= fd_d;
      wbad_q   <= wbad_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      x_q      <= x_d;
      y_q      <= y_d;
      px_q     <= px_d;
      py_q     <= py_d;
      lpx_q    <= lpx_d;
      acth_q   <= acth_d;
      lt_q     <= lt_d;
      maxw_q   <= maxw_d;
      rw_q     <= rw_d;
      rh_q     <= rh_d;
      rlt_q    <= rlt_d;
      fc_q     <= fc_d;
      pp_q     <= pp_d;
      rd_q     <= rd_d;
`ifdef VGA_MON_CHECKSUM_EN
      cks_q    <= cks_d;
      rcks_q   <= rcks_d;
`endif
    end
  end

  assign readdata = rd_q;
  assign irq      = irq_q;

endmodule
